// File: rtl/counter_share_pkg.sv
// counter_share_pkg: shared types and constants for the counter-share arbiter.
package counter_share_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2,
      GAP    = 2'd3
   } state_t;

   localparam int NREQ      = 2;
   localparam int DWELL_DEF = 4;

   function automatic state_t grant_state(input logic idx);
      return idx ? GRANT1 : GRANT0;
   endfunction

endpackage

// File: rtl/counter_share_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker; zero latency, no backpressure.
module rr_pick2
   import counter_share_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic            last,
   output logic            valid,
   output logic            idx
);

   always_comb begin
      valid = |req;
      // On contention the side that did not own the counter last time wins.
      idx   = (req == 2'b11) ? ~last : req[1];
   end

endmodule

// File: rtl/counter_share_arbiter.sv
// counter_share_arbiter: round-robin owner of a shared counter datapath with a dead gap per handoff.
// Grant one edge after req sampled, all outputs registered; ARB_LOCK_EN adds a lock input that blocks preemption.
module counter_share_arbiter
   import counter_share_pkg::*;
#(
   parameter int DWELL = DWELL_DEF,
   parameter int CNT_W = 4
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req,
`ifdef ARB_LOCK_EN
   input  logic             lock,
`endif
   output logic [1:0]       gnt,
   output logic             sel,
   output logic             enable,
   output logic             busy,
   output logic [CNT_W-1:0] dwell_cnt
);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

   state_t           state, state_nxt;
   logic             last, last_nxt;
   logic [1:0]       gnt_nxt;
   logic             sel_nxt, enable_nxt, busy_nxt;
   logic [CNT_W-1:0] dwell_nxt;
   logic             pick_vld, pick_idx;
   logic             own, expired, lock_act;

`ifdef ARB_LOCK_EN
   assign lock_act = lock;
`else
   assign lock_act = 1'b0;
`endif

   rr_pick2 u_pick (
      .req   (req),
      .last  (last),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         last      <= 1'b1;
         gnt       <= 2'b00;
         sel       <= 1'b0;
         enable    <= 1'b0;
         busy      <= 1'b0;
         dwell_cnt <= '0;
      end else begin
         state     <= state_nxt;
         last      <= last_nxt;
         gnt       <= gnt_nxt;
         sel       <= sel_nxt;
         enable    <= enable_nxt;
         busy      <= busy_nxt;
         dwell_cnt <= dwell_nxt;
      end
   end

   always_comb begin
      own       = (state == GRANT1);
      expired   = (dwell_cnt == DWELL_LAST);
      state_nxt = state;
      case (state)
         IDLE, GAP: begin
            state_nxt = pick_vld ? grant_state(pick_idx) : IDLE;
         end
         GRANT0, GRANT1: begin
            // Release and preemption both land in GAP; release is checked first.
            if (!req[own])
               state_nxt = GAP;
            else if (expired && req[!own] && !lock_act)
               state_nxt = GAP;
            else
               state_nxt = state;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt_nxt   = 2'b00;
      sel_nxt   = sel;
      last_nxt  = last;
      dwell_nxt = '0;
      case (state_nxt)
         GRANT0: begin
            gnt_nxt  = 2'b01;
            sel_nxt  = 1'b0;
            last_nxt = 1'b0;
         end
         GRANT1: begin
            gnt_nxt  = 2'b10;
            sel_nxt  = 1'b1;
            last_nxt = 1'b1;
         end
         default: ;
      endcase
      // Continuing the same grant: count, wrapping unless lock holds it at the last value.
      if (state_nxt == state && (state == GRANT0 || state == GRANT1)) begin
         if (expired)
            dwell_nxt = lock_act ? DWELL_LAST : '0;
         else
            dwell_nxt = dwell_cnt + CNT_W'(1);
      end
      enable_nxt = |gnt_nxt;
      busy_nxt   = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Directed self-checking bench for counter_share_arbiter (DWELL=4 and DWELL=1 instances).
module tb_counter_share_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] req = 2'b00;
   logic [1:0] req1 = 2'b00;
   logic       lock = 1'b0;

   logic [1:0] gnt, gnt1;
   logic       sel, sel1, enable, enable1, busy, busy1;
   logic [3:0] dwell_cnt, dwell1;
   logic [8:0] obs, obs1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign obs  = {gnt, sel, enable, busy, dwell_cnt};
   assign obs1 = {gnt1, sel1, enable1, busy1, dwell1};

   counter_share_arbiter #(.DWELL(4), .CNT_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
`ifdef ARB_LOCK_EN
      .lock      (lock),
`endif
      .gnt       (gnt),
      .sel       (sel),
      .enable    (enable),
      .busy      (busy),
      .dwell_cnt (dwell_cnt)
   );

   counter_share_arbiter #(.DWELL(1), .CNT_W(4)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .req       (req1),
`ifdef ARB_LOCK_EN
      .lock      (1'b0),
`endif
      .gnt       (gnt1),
      .sel       (sel1),
      .enable    (enable1),
      .busy      (busy1),
      .dwell_cnt (dwell1)
   );

   // Expected output word: {gnt, sel, enable, busy, dwell_cnt}
   function automatic logic [8:0] mk(input logic [1:0] g, input logic s, input logic e,
                                     input logic b, input logic [3:0] d);
      return {g, s, e, b, d};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req   = 2'b00;
      req1  = 2'b00;
      lock  = 1'b0;
      reset = 1'b1;
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (obs !== mk(2'b00, 1'b0, 1'b0, 1'b0, 4'd0)) begin
         errors++;
         $display("FAIL reset_state: got %b expected %b", obs, mk(2'b00, 1'b0, 1'b0, 1'b0, 4'd0));
      end
      reset = 1'b0;
   endtask

   task automatic test_single();
      logic [8:0] exp [6];
      exp[0] = mk(2'b01, 1'b0, 1'b1, 1'b1, 4'd0);
      exp[1] = mk(2'b01, 1'b0, 1'b1, 1'b1, 4'd1);
      exp[2] = mk(2'b01, 1'b0, 1'b1, 1'b1, 4'd2);
      exp[3] = mk(2'b01, 1'b0, 1'b1, 1'b1, 4'd3);
      exp[4] = mk(2'b01, 1'b0, 1'b1, 1'b1, 4'd0);
      exp[5] = mk(2'b01, 1'b0, 1'b1, 1'b1, 4'd1);
      do_reset();
      req = 2'b01;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("FAIL single_req cycle %0d: got %b expected %b", i, obs, exp[i]);
         end
      end
      req = 2'b00;
      step();
      checks++;
      if (obs !== mk(2'b00, 1'b0, 1'b0, 1'b1, 4'd0)) begin
         errors++;
         $display("FAIL single_release_gap: got %b expected %b", obs, mk(2'b00, 1'b0, 1'b0, 1'b1, 4'd0));
      end
      step();
      checks++;
      if (obs !== mk(2'b00, 1'b0, 1'b0, 1'b0, 4'd0)) begin
         errors++;
         $display("FAIL single_idle: got %b expected %b", obs, mk(2'b00, 1'b0, 1'b0, 1'b0, 4'd0));
      end
   endtask

   task automatic test_both();
      logic [8:0] exp [11];
      for (int i = 0; i < 4; i++) begin
         exp[i]     = mk(2'b01, 1'b0, 1'b1, 1'b1, 4'(i));
         exp[i + 5] = mk(2'b10, 1'b1, 1'b1, 1'b1, 4'(i));
      end
      exp[4]  = mk(2'b00, 1'b0, 1'b0, 1'b1, 4'd0);
      exp[9]  = mk(2'b00, 1'b1, 1'b0, 1'b1, 4'd0);
      exp[10] = mk(2'b01, 1'b0, 1'b1, 1'b1, 4'd0);
      do_reset();
      req = 2'b11;
      for (int i = 0; i < 11; i++) begin
         step();
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("FAIL both_req cycle %0d: got %b expected %b", i, obs, exp[i]);
         end
      end
   endtask

   task automatic test_release();
      do_reset();
      req = 2'b11;
      step();
      step();
      checks++;
      if (obs !== mk(2'b01, 1'b0, 1'b1, 1'b1, 4'd1)) begin
         errors++;
         $display("FAIL release_pre: got %b expected %b", obs, mk(2'b01, 1'b0, 1'b1, 1'b1, 4'd1));
      end
      req = 2'b10;
      step();
      checks++;
      if (obs !== mk(2'b00, 1'b0, 1'b0, 1'b1, 4'd0)) begin
         errors++;
         $display("FAIL release_gap: got %b expected %b", obs, mk(2'b00, 1'b0, 1'b0, 1'b1, 4'd0));
      end
      step();
      checks++;
      if (obs !== mk(2'b10, 1'b1, 1'b1, 1'b1, 4'd0)) begin
         errors++;
         $display("FAIL release_handoff: got %b expected %b", obs, mk(2'b10, 1'b1, 1'b1, 1'b1, 4'd0));
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 2'b11;
      for (int i = 0; i < 8; i++) step();
      checks++;
      if (obs !== mk(2'b10, 1'b1, 1'b1, 1'b1, 4'd2)) begin
         errors++;
         $display("FAIL async_pre: got %b expected %b", obs, mk(2'b10, 1'b1, 1'b1, 1'b1, 4'd2));
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (obs !== mk(2'b00, 1'b0, 1'b0, 1'b0, 4'd0)) begin
         errors++;
         $display("FAIL async_reset: got %b expected %b", obs, mk(2'b00, 1'b0, 1'b0, 1'b0, 4'd0));
      end
      reset = 1'b0;
      step();
      checks++;
      if (obs !== mk(2'b01, 1'b0, 1'b1, 1'b1, 4'd0)) begin
         errors++;
         $display("FAIL async_regrant: got %b expected %b", obs, mk(2'b01, 1'b0, 1'b1, 1'b1, 4'd0));
      end
   endtask

   task automatic test_dwell1();
      logic [8:0] exp [5];
      exp[0] = mk(2'b01, 1'b0, 1'b1, 1'b1, 4'd0);
      exp[1] = mk(2'b00, 1'b0, 1'b0, 1'b1, 4'd0);
      exp[2] = mk(2'b10, 1'b1, 1'b1, 1'b1, 4'd0);
      exp[3] = mk(2'b00, 1'b1, 1'b0, 1'b1, 4'd0);
      exp[4] = mk(2'b01, 1'b0, 1'b1, 1'b1, 4'd0);
      do_reset();
      req1 = 2'b11;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (obs1 !== exp[i]) begin
            errors++;
            $display("FAIL dwell1 cycle %0d: got %b expected %b", i, obs1, exp[i]);
         end
      end
   endtask

`ifdef ARB_LOCK_EN
   task automatic test_lock();
      logic [8:0] exp [6];
      for (int i = 0; i < 6; i++)
         exp[i] = mk(2'b01, 1'b0, 1'b1, 1'b1, (i < 3) ? 4'(i) : 4'd3);
      do_reset();
      req  = 2'b11;
      lock = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("FAIL lock_hold cycle %0d: got %b expected %b", i, obs, exp[i]);
         end
      end
      lock = 1'b0;
      step();
      checks++;
      if (obs !== mk(2'b00, 1'b0, 1'b0, 1'b1, 4'd0)) begin
         errors++;
         $display("FAIL lock_gap: got %b expected %b", obs, mk(2'b00, 1'b0, 1'b0, 1'b1, 4'd0));
      end
      step();
      checks++;
      if (obs !== mk(2'b10, 1'b1, 1'b1, 1'b1, 4'd0)) begin
         errors++;
         $display("FAIL lock_handoff: got %b expected %b", obs, mk(2'b10, 1'b1, 1'b1, 1'b1, 4'd0));
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_both();
      test_release();
      test_async_reset();
      test_dwell1();
`ifdef ARB_LOCK_EN
      test_lock();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
